// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the IF-stage PC/nPC sequencer.
// RESET_PC and EXC_VECTOR are also consumed by the exception unit.
package pc_sequencer_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned INSN_BYTES = 4;

    localparam logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_0080;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        EXC   = 2'd3
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the sequencer and its neighbours: imem, hazard unit,
// ID branch resolution, exception logic and the PC/nPC register pair.
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] npc_q;
    logic              imem_req;
    logic              imem_ack;
    logic              hazard_stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              exc_req;
    logic              pc_le;
    logic              npc_le;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] npc_d;
    logic              flush;
    logic              exc_ack;
    logic              misalign;
    logic [ADDR_W-1:0] epc;

    modport master (
        input  pc_q, npc_q, imem_ack, hazard_stall, branch_taken, branch_target, exc_req,
        output imem_req, pc_le, npc_le, pc_d, npc_d, flush, exc_ack, misalign, epc
    );

    modport slave (
        output pc_q, npc_q, imem_ack, hazard_stall, branch_taken, branch_target, exc_req,
        input  imem_req, pc_le, npc_le, pc_d, npc_d, flush, exc_ack, misalign, epc
    );

endinterface

// File: rtl/pc_sequencer.sv
// Decides each cycle whether PC/nPC advance, hold or redirect, and supplies
// their next values; the delay slot falls out of loading pc_d from npc_q.
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.master bus
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSN_BYTES);

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] epc_q;
    logic              epc_le;
    logic              have_word;
    logic              advance;
    logic              bad_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            epc_q <= '0;
        end else begin
            state <= state_nxt;
            if (epc_le) epc_q <= bus.pc_q;
        end
    end

    assign bus.epc = epc_q;

    // HOLD already owns a fetched word, so it advances without a fresh ack.
    assign have_word  = (state == HOLD) || bus.imem_ack;
    assign advance    = have_word && !bus.hazard_stall;
    assign bad_target = bus.branch_taken && (bus.branch_target[1:0] != 2'b00);

    always_comb begin
        state_nxt     = state;
        epc_le        = 1'b0;
        bus.imem_req  = 1'b0;
        bus.pc_le     = 1'b0;
        bus.npc_le    = 1'b0;
        bus.pc_d      = RESET_PC;
        bus.npc_d     = RESET_PC + STEP;
        bus.flush     = 1'b0;
        bus.exc_ack   = 1'b0;
        bus.misalign  = 1'b0;

        unique case (state)
            INIT: begin
                bus.pc_le  = 1'b1;
                bus.npc_le = 1'b1;
                state_nxt  = FETCH;
            end
            FETCH, HOLD: begin
                bus.imem_req = (state == FETCH) && !bus.exc_req;
                if (bus.exc_req) begin
                    bus.flush   = 1'b1;
                    bus.exc_ack = 1'b1;
                    epc_le      = 1'b1;
                    state_nxt   = EXC;
                end else if (advance && bad_target) begin
                    bus.misalign = 1'b1;
                    bus.flush    = 1'b1;
                    bus.exc_ack  = 1'b1;
                    epc_le       = 1'b1;
                    state_nxt    = EXC;
                end else if (advance) begin
                    bus.pc_le  = 1'b1;
                    bus.npc_le = 1'b1;
                    bus.pc_d   = bus.npc_q;
                    bus.npc_d  = bus.branch_taken ? bus.branch_target : bus.npc_q + STEP;
                    state_nxt  = FETCH;
                end else if (have_word) begin
                    state_nxt  = HOLD;
                end
            end
            EXC: begin
                bus.pc_le  = 1'b1;
                bus.npc_le = 1'b1;
                bus.pc_d   = EXC_VECTOR;
                bus.npc_d  = EXC_VECTOR + STEP;
                bus.flush  = 1'b1;
                state_nxt  = FETCH;
            end
            default: state_nxt = INIT;
        endcase

        // Reset must kill every strobe immediately, independent of state.
        if (!rst_n) begin
            epc_le       = 1'b0;
            bus.imem_req = 1'b0;
            bus.pc_le    = 1'b0;
            bus.npc_le   = 1'b0;
            bus.pc_d     = RESET_PC;
            bus.npc_d    = RESET_PC + STEP;
            bus.flush    = 1'b0;
            bus.exc_ack  = 1'b0;
            bus.misalign = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer; the bench owns the PC/nPC
// register pair and predicts every strobe from a phase-level behavioural model.
module tb_pc_sequencer;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] pc_reg;
    logic [31:0] npc_reg;

    assign bus.pc_q  = pc_reg;
    assign bus.npc_q = npc_reg;

    always_ff @(posedge clk) begin
        if (bus.pc_le)  pc_reg  <= bus.pc_d;
        if (bus.npc_le) npc_reg <= bus.npc_d;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: boot = first cycle after reset, vector = redirect cycle,
    // latched = fetched word waiting on a stall.
    bit          m_boot;
    bit          m_vector;
    bit          m_latched;
    bit          m_loaded;
    logic [31:0] m_pc;
    logic [31:0] m_npc;
    logic [31:0] m_epc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic ack, input logic stall, input logic bt,
                         input logic [31:0] tgt, input logic exc);
        logic        e_req, e_le, e_flush, e_ack, e_mis, cap, go, word;
        logic [31:0] e_pc_d, e_npc_d;
        bus.imem_ack      = ack;
        bus.hazard_stall  = stall;
        bus.branch_taken  = bt;
        bus.branch_target = tgt;
        bus.exc_req       = exc;
        #1;
        e_req = 0; e_le = 0; e_flush = 0; e_ack = 0; e_mis = 0; cap = 0;
        e_pc_d = 32'h0; e_npc_d = 32'h0;
        if (m_boot) begin
            e_le = 1; e_pc_d = 32'h0; e_npc_d = 32'h4;
            m_boot = 0;
        end else if (m_vector) begin
            e_le = 1; e_flush = 1; e_pc_d = 32'h80; e_npc_d = 32'h84;
            m_vector = 0;
        end else begin
            e_req = !m_latched && !exc;
            word  = m_latched || ack;
            go    = word && !stall;
            if (exc || (go && bt && tgt[1:0] != 2'b00)) begin
                e_flush = 1; e_ack = 1; cap = 1;
                e_mis = !exc;
                m_vector = 1; m_latched = 0;
            end else if (go) begin
                e_le = 1; e_pc_d = m_npc;
                e_npc_d = bt ? tgt : m_npc + 32'd4;
                m_latched = 0;
            end else begin
                m_latched = word;
            end
        end
        chk("imem_req", 32'(bus.imem_req), 32'(e_req));
        chk("pc_le",    32'(bus.pc_le),    32'(e_le));
        chk("npc_le",   32'(bus.npc_le),   32'(e_le));
        chk("flush",    32'(bus.flush),    32'(e_flush));
        chk("exc_ack",  32'(bus.exc_ack),  32'(e_ack));
        chk("misalign", 32'(bus.misalign), 32'(e_mis));
        if (e_le) begin
            chk("pc_d",  bus.pc_d,  e_pc_d);
            chk("npc_d", bus.npc_d, e_npc_d);
            m_pc = e_pc_d; m_npc = e_npc_d; m_loaded = 1;
        end
        if (cap) m_epc = m_pc;
        @(posedge clk);
        #1;
        if (m_loaded) begin
            chk("pc_q",  pc_reg,  m_pc);
            chk("npc_q", npc_reg, m_npc);
        end
        chk("epc", bus.epc, m_epc);
    endtask

    task automatic reset_checks();
        chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
        chk("rst_pc_le",    32'(bus.pc_le),    32'h0);
        chk("rst_npc_le",   32'(bus.npc_le),   32'h0);
        chk("rst_flush",    32'(bus.flush),    32'h0);
        chk("rst_exc_ack",  32'(bus.exc_ack),  32'h0);
        chk("rst_misalign", 32'(bus.misalign), 32'h0);
        chk("rst_pc_d",     bus.pc_d,          32'h0);
        chk("rst_npc_d",    bus.npc_d,         32'h4);
        chk("rst_epc",      bus.epc,           32'h0);
    endtask

    // Pulls reset mid-cycle, then releases it just after a rising edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        m_boot    = 1;
        m_vector  = 0;
        m_latched = 0;
        m_epc     = 32'h0;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] tgt;
        errors = 0;
        checks = 0;
        m_boot = 0; m_vector = 0; m_latched = 0; m_loaded = 0;
        m_pc = 32'h0; m_npc = 32'h0; m_epc = 32'h0;
        rst_n = 1'b0;
        bus.imem_ack = 0; bus.hazard_stall = 0; bus.branch_taken = 0;
        bus.branch_target = 32'h0; bus.exc_req = 0;
        #1;
        reset_checks();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_boot = 1;

        // Boot and sequential flow.
        cycle(0, 0, 0, 32'h0, 0);
        chk("boot_pc", pc_reg, 32'h0);
        chk("boot_npc", npc_reg, 32'h4);
        cycle(1, 0, 0, 32'h0, 0);  chk("seq_pc4", pc_reg, 32'h4);
        cycle(1, 0, 0, 32'h0, 0);  chk("seq_pc8", pc_reg, 32'h8);
        cycle(1, 0, 0, 32'h0, 0);  chk("seq_pc12", pc_reg, 32'hC);
        cycle(1, 0, 0, 32'h0, 0);  chk("seq_npc", npc_reg, 32'h14);

        // Taken branch with delay slot.
        cycle(1, 0, 1, 32'h40, 0); chk("br_slot", pc_reg, 32'h14);
        cycle(1, 0, 0, 32'h0, 0);  chk("br_tgt", pc_reg, 32'h40);
        cycle(1, 0, 0, 32'h0, 0);  chk("br_next", pc_reg, 32'h44);

        // Stall with ack: HOLD for three cycles, then release without ack.
        cycle(1, 1, 0, 32'h0, 0);
        cycle(1, 1, 0, 32'h0, 0);
        cycle(1, 1, 0, 32'h0, 0);  chk("hold_pc", pc_reg, 32'h44);
        cycle(0, 0, 0, 32'h0, 0);  chk("hold_rel", pc_reg, 32'h48);

        // Exception while waiting on ack at pc 0x24.
        cycle(1, 0, 1, 32'h24, 0);
        cycle(1, 0, 0, 32'h0, 0);  chk("exc_at", pc_reg, 32'h24);
        cycle(0, 0, 0, 32'h0, 1);  chk("exc_epc", bus.epc, 32'h24);
        cycle(0, 0, 0, 32'h0, 0);
        chk("exc_pc", pc_reg, 32'h80);
        chk("exc_npc", npc_reg, 32'h84);

        // Misaligned branch target redirects instead of branching.
        cycle(1, 0, 1, 32'h42, 0); chk("mis_epc", bus.epc, 32'h80);
        cycle(0, 0, 0, 32'h0, 0);
        chk("mis_pc", pc_reg, 32'h80);
        chk("mis_npc", npc_reg, 32'h84);

        // Incrementer wrap.
        cycle(1, 0, 1, 32'hFFFF_FFFC, 0);
        cycle(1, 0, 0, 32'h0, 0);
        chk("wrap_pc", pc_reg, 32'hFFFF_FFFC);
        chk("wrap_npc", npc_reg, 32'h0);
        cycle(1, 0, 0, 32'h0, 0);  chk("wrap_after", pc_reg, 32'h0);

        // Reset while a fetch is outstanding: imem_req must drop at once.
        bus.imem_ack = 0; bus.hazard_stall = 0; bus.branch_taken = 0; bus.exc_req = 0;
        #1;
        chk("req_pending", 32'(bus.imem_req), 32'h1);
        do_reset();
        cycle(0, 0, 0, 32'h0, 0);

        // Reset during HOLD.
        cycle(1, 0, 0, 32'h0, 0);
        cycle(1, 1, 0, 32'h0, 0);
        do_reset();
        cycle(0, 0, 0, 32'h0, 0);
        chk("rst_boot_pc", pc_reg, 32'h0);
        chk("rst_boot_npc", npc_reg, 32'h4);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r   = $urandom();
            tgt = {r[31:2], 2'b00};
            if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            cycle(1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 4) == 0),
                  tgt,
                  1'($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
